// File: rtl/spiker_run_ctrl.sv
// ---------------------------------------------------------------------------
// spiker_run_ctrl
//
// Run sequencer for the spiker adapter datapath. A start command from the
// register file launches a run of n_steps_i timesteps: the core receives one
// step_o pulse per timestep and answers each with core_done_i. After the last
// timestep the writer gets a single sample_o pulse; once it reports
// writer_ready_i the run is flagged done and a sticky interrupt is raised.
//
// Build option:
//   SPIKER_RUN_CTRL_WATCHDOG_EN  - adds a TIMEOUT_W-bit watchdog on the two
//                                  wait states; expiry ends the run with
//                                  error_o/irq_o. Undefined: waits block
//                                  indefinitely and error_o is tied low.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   start_i         one-cycle run request (honoured only when idle)
//   n_steps_i       timesteps per run, latched on an accepted start
//   abort_i         cancel the current run
//   irq_clr_i       clear irq_o and done_o
//   step_o          one-cycle pulse: core executes one timestep
//   core_done_i     one-cycle pulse: core finished the current timestep
//   core_en_o       core enable for the whole active run
//   sample_o        one-cycle pulse to the writer sample input
//   writer_ready_i  writer result registers updated (level)
//   busy_o          sequencer not idle
//   step_cnt_o      completed timesteps in the current/last run
//   done_o          sticky: last run completed normally
//   error_o         sticky: last run ended by the watchdog
//   irq_o           sticky interrupt
//
// States:
//   state       | meaning
//   ------------+-----------------------------------------------
//   IDLE        | waiting for start_i
//   STEP        | step_o high for this cycle
//   WAIT_CORE   | waiting for core_done_i of the current timestep
//   SAMPLE      | sample_o high for this cycle
//   WAIT_WR     | waiting for writer_ready_i
// ---------------------------------------------------------------------------
module spiker_run_ctrl #(
    parameter int STEP_W    = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [STEP_W-1:0] n_steps_i,
    input  logic              abort_i,
    input  logic              irq_clr_i,
    output logic              step_o,
    input  logic              core_done_i,
    output logic              core_en_o,
    output logic              sample_o,
    input  logic              writer_ready_i,
    output logic              busy_o,
    output logic [STEP_W-1:0] step_cnt_o,
    output logic              done_o,
    output logic              error_o,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_WAIT_CORE = 3'd2,
        S_SAMPLE    = 3'd3,
        S_WAIT_WR   = 3'd4
    } state_t;

    generate
        if (STEP_W < 1) begin : g_bad_step_w
            $error("spiker_run_ctrl: STEP_W must be at least 1");
        end
        if (TIMEOUT_W < 2) begin : g_bad_timeout_w
            $error("spiker_run_ctrl: TIMEOUT_W must be at least 2");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]   cnt_inc;
    logic [STEP_W-1:0]   nlat_q, nlat_d;
    logic                done_q, done_d;
    logic                irq_q, irq_d;
    logic                step_q, sample_q, busy_q, core_en_q;

`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic                 wd_expire;
    logic                 error_q, error_d;
`endif

    assign cnt_inc = cnt_q + {{(STEP_W-1){1'b0}}, 1'b1};

`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
    // The count reaching all-ones ends the wait; a response arriving in that
    // same cycle takes priority, so expiry is qualified by the missing response.
    assign wd_inc    = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    assign wd_expire = (&wd_inc) &&
                       (((state_q == S_WAIT_CORE) && !core_done_i) ||
                        ((state_q == S_WAIT_WR)   && !writer_ready_i));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nlat_d  = nlat_q;
        // Clear first so that any set below in the same cycle wins.
        done_d  = done_q & ~irq_clr_i;
        irq_d   = irq_q  & ~irq_clr_i;
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
        error_d = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                    if (n_steps_i == '0) begin
                        // Empty run completes on the spot.
                        done_d = 1'b1;
                        irq_d  = 1'b1;
                    end else begin
                        nlat_d  = n_steps_i;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done_i) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == nlat_q) ? S_SAMPLE : S_STEP;
                end
            end
            S_SAMPLE: begin
                state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (writer_ready_i) begin
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
        if (wd_expire) begin
            error_d = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
        end
`endif

        // Abort overrides anything decided above for an active run.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            done_d  = done_q & ~irq_clr_i;
            irq_d   = irq_q  & ~irq_clr_i;
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
            error_d = error_q;
`endif
        end
    end

`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
    // Restart on every entry into a wait state, count while staying in it.
    always_comb begin
        wd_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_WAIT_CORE) || (state_q == S_WAIT_WR))) begin
            wd_d = wd_inc;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nlat_q    <= '0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            step_q    <= 1'b0;
            sample_q  <= 1'b0;
            busy_q    <= 1'b0;
            core_en_q <= 1'b0;
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
            wd_q      <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nlat_q    <= nlat_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            // Outputs decoded from the next state so they align with it.
            step_q    <= (state_d == S_STEP);
            sample_q  <= (state_d == S_SAMPLE);
            busy_q    <= (state_d != S_IDLE);
            core_en_q <= (state_d != S_IDLE);
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
            wd_q      <= wd_d;
            error_q   <= error_d;
`endif
        end
    end

    assign step_o     = step_q;
    assign sample_o   = sample_q;
    assign busy_o     = busy_q;
    assign core_en_o  = core_en_q;
    assign step_cnt_o = cnt_q;
    assign done_o     = done_q;
    assign irq_o      = irq_q;
`ifdef SPIKER_RUN_CTRL_WATCHDOG_EN
    assign error_o    = error_q;
`else
    assign error_o    = 1'b0;
`endif

endmodule
